// File: rtl/anillo_multimodo.sv
// Parametrised ring / Johnson sequence counter with up/down stepping, parallel load,
// wrap pulse and illegal-state flag. Optional macro ANILLO_AUTOCORRECT_EN re-seeds illegal states.
module anillo_multimodo #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         dir,
    input  logic         mode,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         tc,
    output logic         err
);

    typedef enum logic {
        MODE_RING    = 1'b0,
        MODE_JOHNSON = 1'b1
    } mode_e;

    mode_e        mode_q, mode_d, mode_in;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] step_val;
    logic [N-1:0] init_cur;
    logic [N-1:0] init_new;
    logic         step_wraps;
    logic         err_ring;
    logic         err_john;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= {{(N-1){1'b0}}, 1'b1};
            mode_q <= MODE_RING;
        end else begin
            q_q    <= q_d;
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_in  = mode_e'(mode);
        init_cur = (mode_q == MODE_RING) ? {{(N-1){1'b0}}, 1'b1} : '0;
        init_new = (mode_in == MODE_RING) ? {{(N-1){1'b0}}, 1'b1} : '0;

        // The feedback bit is inverted only in Johnson mode.
        if (dir)
            step_val = {q_q[0] ^ (mode_q == MODE_JOHNSON), q_q[N-1:1]};
        else
            step_val = {q_q[N-2:0], q_q[N-1] ^ (mode_q == MODE_JOHNSON)};

        err_ring = ($countones(q_q) != 1);
        err_john = ($countones(q_q[N-1:1] ^ q_q[N-2:0]) > 1);
        err      = (mode_q == MODE_RING) ? err_ring : err_john;

        step_wraps = (step_val == init_cur);
`ifdef ANILLO_AUTOCORRECT_EN
        tc = en & ~load & ~rst & (mode_in == mode_q) & step_wraps & ~err;
`else
        tc = en & ~load & ~rst & (mode_in == mode_q) & step_wraps;
`endif

        q_d    = q_q;
        mode_d = mode_q;
        if (load) begin
            q_d    = d;
            mode_d = mode_in;
        end else if (mode_in != mode_q) begin
            q_d    = init_new;
            mode_d = mode_in;
        end else if (en) begin
`ifdef ANILLO_AUTOCORRECT_EN
            q_d = err ? init_cur : step_val;
`else
            q_d = step_val;
`endif
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_anillo_multimodo.sv
// Self-checking bench for anillo_multimodo: directed scenarios plus random stimulus
// compared against an arithmetic reference model.
module tb_anillo_multimodo;

    localparam int unsigned N    = 4;
    localparam int unsigned MASK = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst, en, dir, mode, load;
    logic [N-1:0] d;
    logic [N-1:0] q;
    logic         tc, err;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] m_q;
    bit           m_john;

    anillo_multimodo #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .dir  (dir),
        .mode (mode),
        .load (load),
        .d    (d),
        .q    (q),
        .tc   (tc),
        .err  (err)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] m_init(input bit john);
        return john ? N'(0) : N'(1);
    endfunction

    // Rotation / twisted rotation expressed as integer arithmetic.
    function automatic logic [N-1:0] m_shift(input logic [N-1:0] v, input bit john, input bit right);
        int unsigned x, fill;
        x = int'(v);
        if (!right) begin
            fill = (x >> (N - 1)) & 1;
            if (john) fill = 1 - fill;
            x = ((x << 1) | fill) & MASK;
        end else begin
            fill = x & 1;
            if (john) fill = 1 - fill;
            x = (x >> 1) | (fill << (N - 1));
        end
        return N'(x);
    endfunction

    function automatic bit m_err(input logic [N-1:0] v, input bit john);
        int unsigned x;
        x = int'(v);
        if (john) return $countones((x ^ (x >> 1)) & (MASK >> 1)) > 1;
        return $countones(x) != 1;
    endfunction

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check combinational outputs, advance model, check q.
    task automatic cyc(input bit r, input bit e, input bit di, input bit mo, input bit lo,
                       input logic [N-1:0] dd);
        bit exp_tc, exp_err;
        @(negedge clk);
        rst = r; en = e; dir = di; mode = mo; load = lo; d = dd;
        #1;
        exp_err = m_err(m_q, m_john);
        exp_tc  = e && !lo && !r && (mo == m_john) && (m_shift(m_q, m_john, di) == m_init(m_john));
`ifdef ANILLO_AUTOCORRECT_EN
        if (exp_err) exp_tc = 1'b0;
`endif
        chk("tc", N'(tc), N'(exp_tc));
        chk("err", N'(err), N'(exp_err));
        @(posedge clk);
        if (r) begin
            m_q = N'(1); m_john = 1'b0;
        end else if (lo) begin
            m_q = dd; m_john = mo;
        end else if (mo != m_john) begin
            m_q = m_init(mo); m_john = mo;
        end else if (e) begin
`ifdef ANILLO_AUTOCORRECT_EN
            if (m_err(m_q, m_john)) m_q = m_init(m_john);
            else m_q = m_shift(m_q, m_john, di);
`else
            m_q = m_shift(m_q, m_john, di);
`endif
        end
        #1;
        chk("q", q, m_q);
    endtask

    initial begin
        bit r, lo, mo;
        int unsigned p;
        rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; d = '0;
        @(posedge clk);
        #1;
        m_q = N'(1); m_john = 1'b0;
        chk("reset_q", q, 4'b0001);
        chk("reset_err", N'(err), N'(0));

        // Ring, left.
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, '0);
        chk("ring_left_wrap", q, 4'b0001);
        // Ring, right, with a dir toggle at 0100.
        cyc(0, 1, 1, 0, 0, '0);
        chk("ring_right_1", q, 4'b1000);
        cyc(0, 1, 1, 0, 0, '0);
        chk("ring_right_2", q, 4'b0100);
        cyc(0, 1, 0, 0, 0, '0);
        chk("dir_toggle", q, 4'b1000);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0, '0);
        // Mode change with en=0 reinitialises.
        cyc(0, 1, 0, 0, 0, '0);
        cyc(0, 0, 0, 1, 0, '0);
        chk("mode_change", q, 4'b0000);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 1, 0, '0);
        chk("johnson_wrap", q, 4'b0000);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 1, 0, '0);
        // Illegal ring load.
        cyc(0, 0, 0, 0, 1, 4'b0110);
        chk("load_illegal", q, 4'b0110);
        cyc(0, 1, 0, 0, 0, '0);
`ifdef ANILLO_AUTOCORRECT_EN
        chk("illegal_step", q, 4'b0001);
`else
        chk("illegal_step", q, 4'b1100);
`endif
        cyc(0, 1, 0, 0, 0, '0);
        // Reset beats load.
        cyc(1, 1, 0, 1, 1, 4'b1010);
        chk("rst_over_load", q, 4'b0001);
        cyc(0, 0, 0, 1, 1, 4'b0111);
        chk("load_johnson", q, 4'b0111);
        cyc(0, 1, 0, 1, 0, '0);
        chk("johnson_step", q, 4'b1111);
        cyc(0, 1, 0, 1, 0, '0);
        chk("johnson_1110", q, 4'b1110);
        cyc(1, 1, 0, 1, 0, '0);
        chk("reset_midrun", q, 4'b0001);
        cyc(0, 1, 0, 0, 0, '0);
        chk("resume_ring", q, 4'b0010);

        for (int i = 0; i < 400; i++) begin
            p  = $urandom_range(0, 99);
            r  = (p < 3);
            lo = (p >= 3 && p < 10);
            mo = ($urandom_range(0, 99) < 6) ? !m_john : m_john;
            cyc(r, $urandom_range(0, 9) < 8, 1'($urandom), mo, lo, N'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
